// File: rtl/deser_pkg.sv
// Shared types and constants for the serial-link deserializer.
package deser_pkg;

   typedef enum logic [1:0] {
      HUNT,
      CONFIRM,
      LOCKED
   } state_t;

   localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/deserializer.sv
// MSB-first deserializer: hunts for SYNC_WORD, confirms over LOCK_CNT frames, then emits bytes.
// Build option DESER_SYNC_DROP_EN: SYNC_WORD frames seen while locked are dropped as idle filler.
module deserializer
   import deser_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(DEFAULT_SYNC_WORD),
   parameter int                LOCK_CNT  = 2
) (
   input  logic              t_clk,
   input  logic              rst_n,
   input  logic              ser_in,
   input  logic              relock,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              locked
);

   localparam int                 BIT_W      = cnt_w(DATA_W);
   localparam int                 MATCH_W    = cnt_w(LOCK_CNT + 1);
   localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_W - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  sreg_q, sreg_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d, bit_nxt;
   logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               valid_q, valid_d;
   logic               sync_hit, boundary;

   assign sync_hit = (sreg_q == SYNC_WORD);
   assign boundary = (bit_cnt_q == '0);
   assign bit_nxt  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
   assign sreg_d   = {sreg_q[DATA_W-2:0], ser_in};

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      match_cnt_d = match_cnt_q;
      data_d      = data_q;
      valid_d     = 1'b0;

      if (relock) begin
         state_d     = HUNT;
         match_cnt_d = '0;
      end else begin
         unique case (state_q)
            HUNT: begin
               if (sync_hit) begin
                  bit_cnt_d   = BIT_W'(1);
                  match_cnt_d = MATCH_W'(1);
                  state_d     = (LOCK_CNT == 1) ? LOCKED : CONFIRM;
               end
            end
            CONFIRM: begin
               bit_cnt_d = bit_nxt;
               if (boundary) begin
                  if (sync_hit) begin
                     match_cnt_d = match_cnt_q + 1'b1;
                     if (match_cnt_q == MATCH_LAST) state_d = LOCKED;
                  end else begin
                     // A failed confirm frame is not rechecked as a fresh hunt match.
                     state_d     = HUNT;
                     match_cnt_d = '0;
                  end
               end
            end
            LOCKED: begin
               bit_cnt_d = bit_nxt;
               if (boundary) begin
`ifdef DESER_SYNC_DROP_EN
                  if (!sync_hit) begin
                     data_d  = sreg_q;
                     valid_d = 1'b1;
                  end
`else
                  data_d  = sreg_q;
                  valid_d = 1'b1;
`endif
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge t_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q     <= HUNT;
         sreg_q      <= '0;
         bit_cnt_q   <= '0;
         match_cnt_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         bit_cnt_q   <= bit_cnt_d;
         match_cnt_q <= match_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: lock, alignment, failed confirm, relock and sync-drop scenarios.
module tb_deserializer;

   logic       t_clk = 1'b0;
   logic       rst_n;
   logic       ser_in;
   logic       relock;
   logic [7:0] data_out;
   logic       data_valid;
   logic       locked;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_edge = 0;

   logic [7:0] got_d[$];
   int         got_c[$];
   logic [7:0] exp_d[$];
   int         exp_c[$];
   int         lk_got[$];
   int         lk_exp[$];
   logic       locked_prev = 1'b0;

   deserializer dut (
      .t_clk     (t_clk),
      .rst_n     (rst_n),
      .ser_in    (ser_in),
      .relock    (relock),
      .data_out  (data_out),
      .data_valid(data_valid),
      .locked    (locked)
   );

   always #5 t_clk = ~t_clk;

   always @(posedge t_clk) cyc <= cyc + 1;

   // Strobes and lock rises are logged on the falling edge with the count of rising edges so far.
   always @(negedge t_clk) begin
      if (data_valid === 1'b1) begin
         got_d.push_back(data_out);
         got_c.push_back(cyc);
      end
      if (locked === 1'b1 && !locked_prev) lk_got.push_back(cyc);
      locked_prev = (locked === 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      ser_in = b;
      @(posedge t_clk);
      #1;
      last_edge = cyc;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit emit);
      send_byte(b);
      if (emit) begin
         exp_d.push_back(b);
         exp_c.push_back(last_edge + 1);
      end
   endtask

   task automatic send_sync_pair();
      send_byte(8'hA5);
      send_byte(8'hA5);
      lk_exp.push_back(last_edge + 1);
   endtask

   task automatic flush(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   task automatic settle();
      @(negedge t_clk);
      #1;
   endtask

   task automatic do_relock(input string tag, input logic [7:0] held);
      relock = 1'b1;
      send_bit(1'b0);
      relock = 1'b0;
      check({tag, "_locked"}, locked, 0);
      check({tag, "_held"}, data_out, held);
   endtask

   task automatic check_strobes(input string tag);
      int n;
      check({tag, "_count"}, got_d.size(), exp_d.size());
      n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
         check($sformatf("%s_cyc%0d", tag, i), got_c[i], exp_c[i]);
      end
      got_d.delete(); got_c.delete(); exp_d.delete(); exp_c.delete();
   endtask

   task automatic check_locks(input string tag);
      int n;
      check({tag, "_count"}, lk_got.size(), lk_exp.size());
      n = (lk_got.size() < lk_exp.size()) ? lk_got.size() : lk_exp.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_cyc%0d", tag, i), lk_got[i], lk_exp[i]);
      lk_got.delete(); lk_exp.delete();
   endtask

   initial begin
      rst_n  = 1'b0;
      relock = 1'b0;
      ser_in = 1'b0;

      // Reset with random serial activity.
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
      check("rst_data", data_out, 0);
      check("rst_valid", data_valid, 0);
      check("rst_locked", locked, 0);
      rst_n = 1'b1;

      // Lock from reset, then aligned data.
      send_sync_pair();
      check("boundary_not_locked", locked, 0);
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_bit(1'b0);
      settle();
      check("aligned_locked", locked, 1);
      check_locks("lock_reset");
      check_strobes("aligned");

      // Three stray bits before the sync pair shift the frame phase.
      do_relock("relock_a", 8'hFF);
      flush(8);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      send_sync_pair();
      send_frame(8'h5A, 1'b1);
      send_bit(1'b0);
      settle();
      check_locks("lock_misalign");
      check_strobes("misalign");

      // Sync then a non-sync frame drops back to hunting without lock.
      do_relock("relock_b", 8'h5A);
      flush(8);
      send_byte(8'hA5);
      send_byte(8'h12);
      check("fail_confirm_locked", locked, 0);
      send_sync_pair();
      send_frame(8'h66, 1'b1);

      // Relock at bit 4 of the next data frame suppresses that frame.
      for (int i = 7; i >= 0; i--) begin
         if (i == 3) relock = 1'b1;
         send_bit(8'h99 >> i);
         relock = 1'b0;
         if (i == 3) begin
            check("mid_relock_locked", locked, 0);
            check("mid_relock_valid", data_valid, 0);
         end
      end
      flush(8);
      settle();
      check("mid_relock_held", data_out, 8'h66);
      check_strobes("mid_relock");

      send_sync_pair();
      send_frame(8'h42, 1'b1);

      // Sync words inside locked traffic.
`ifdef DESER_SYNC_DROP_EN
      send_frame(8'hA5, 1'b0);
      send_frame(8'h77, 1'b1);
      send_frame(8'hA5, 1'b0);
      send_frame(8'h88, 1'b1);
`else
      send_frame(8'hA5, 1'b1);
      send_frame(8'h77, 1'b1);
      send_frame(8'hA5, 1'b1);
      send_frame(8'h88, 1'b1);
`endif
      send_bit(1'b0);
      settle();
      check_locks("lock_relock");
      check_strobes("sync_drop");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
